// File: rtl/map_display_controller_if.sv
// Map-store lookup and VGA plotter signals of the map display controller.
// master = map display controller, slave = map store / frame-buffer plotter side.
interface map_display_controller_if;
    logic [4:0] map_x;
    logic [4:0] map_y;
    logic [2:0] spriteType;
    logic       vgaPlot;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vgaColor;

    modport master (
        output map_x, map_y, vgaPlot, vga_x, vga_y, vgaColor,
        input  spriteType
    );
    modport slave (
        input  map_x, map_y, vgaPlot, vga_x, vga_y, vgaColor,
        output spriteType
    );
endinterface

// File: rtl/map_display_controller.sv
// Scans the tile map one pixel per enabled clock and expands each tile's sprite into a 5x5 pattern.
// Optional macro MAP_DISPLAY_DEBUG_EN drives debugLEDs with {spriteType, tile row}.
module map_display_controller #(
    parameter int TILES   = 21,
    parameter int TILE_PX = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    map_display_controller_if.master  bus,
    output logic [7:0]                debugLEDs
);
    logic [2:0] px, py;
    logic [4:0] tx, ty;

    // px fastest, then py, then tx, then ty; the last pixel wraps straight to the first
    always_ff @(posedge clk) begin
        if (reset) begin
            px <= '0;
            py <= '0;
            tx <= '0;
            ty <= '0;
        end else if (en) begin
            if (px == 3'(TILE_PX - 1)) begin
                px <= '0;
                if (py == 3'(TILE_PX - 1)) begin
                    py <= '0;
                    if (tx == 5'(TILES - 1)) begin
                        tx <= '0;
                        ty <= (ty == 5'(TILES - 1)) ? 5'd0 : ty + 5'd1;
                    end else begin
                        tx <= tx + 5'd1;
                    end
                end else begin
                    py <= py + 3'd1;
                end
            end else begin
                px <= px + 3'd1;
            end
        end
    end

    // Outputs read as the origin while reset is asserted, even before the first edge clears state
    logic [2:0] cur_px, cur_py;
    logic [4:0] cur_tx, cur_ty;
    assign cur_px = reset ? 3'd0 : px;
    assign cur_py = reset ? 3'd0 : py;
    assign cur_tx = reset ? 5'd0 : tx;
    assign cur_ty = reset ? 5'd0 : ty;

    assign bus.map_x   = cur_tx;
    assign bus.map_y   = cur_ty;
    assign bus.vga_x   = 8'(cur_tx) * 8'(TILE_PX) + 8'(cur_px);
    assign bus.vga_y   = 8'(cur_ty) * 8'(TILE_PX) + 8'(cur_py);
    assign bus.vgaPlot = en & ~reset;

    logic [2:0] color;
    always_comb begin
        color = 3'b000;
        case (bus.spriteType)
            3'd1: color = 3'b001;
            3'd2: if (cur_px == 3'd2 && cur_py == 3'd2) color = 3'b111;
            3'd3: if (cur_px >= 3'd1 && cur_px <= 3'd3 &&
                      cur_py >= 3'd1 && cur_py <= 3'd3) color = 3'b111;
            3'd4: if (cur_py == 3'd2) color = 3'b101;
            default: color = 3'b000;
        endcase
    end
    assign bus.vgaColor = color;

`ifdef MAP_DISPLAY_DEBUG_EN
    assign debugLEDs = {bus.spriteType, cur_ty};
`else
    assign debugLEDs = 8'h00;
`endif
endmodule

// File: tb/tb_map_display_controller.sv
// Directed bench for map_display_controller: reset, scan order, patterns, wrap, enable hold, debug LEDs.
module tb_map_display_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] debugLEDs;
    int         n_checks = 0;
    int         n_errors = 0;

    map_display_controller_if bus ();

    map_display_controller dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .bus       (bus.master),
        .debugLEDs (debugLEDs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int mx, input int my, input int vx, input int vy);
        check({tag, " map_x"}, 32'(bus.map_x), 32'(mx));
        check({tag, " map_y"}, 32'(bus.map_y), 32'(my));
        check({tag, " vga_x"}, 32'(bus.vga_x), 32'(vx));
        check({tag, " vga_y"}, 32'(bus.vga_y), 32'(vy));
    endtask

    // Leaves the bench at a negedge with the scan at the origin and en low
    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one tile (25 cycles) with the given sprite; returns number of cycles showing colour c
    task automatic tile_scan(input logic [2:0] s, input logic [2:0] c, output int hits, output int first_hit);
        hits = 0;
        first_hit = -1;
        reset_pulse();
        bus.spriteType = s;
        en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            #1;
            if (bus.vgaColor == c) begin
                if (first_hit < 0) first_hit = k + 1;
                hits++;
            end else begin
                check($sformatf("spr%0d bg px%0d", s, k), 32'(bus.vgaColor), 32'd0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int hits, first;
        int tile, p;

        reset = 1'b1;
        en = 1'b1;
        bus.spriteType = 3'd1;
        repeat (3) @(negedge clk);
        #1;
        check_pos("in reset", 0, 0, 0, 0);
        check("in reset vgaPlot", 32'(bus.vgaPlot), 32'd0);
        check("in reset color", 32'(bus.vgaColor), 32'b001);
        check("in reset debug", 32'(debugLEDs), 32'h00);

        @(negedge clk);
        reset = 1'b0;
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_pos($sformatf("idle %0d", k), 0, 0, 0, 0);
            check("idle vgaPlot", 32'(bus.vgaPlot), 32'd0);
            @(negedge clk);
        end

        // Wall tile: pixel walk within tile (0,0), then step into tile 1
        bus.spriteType = 3'd1;
        en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            #1;
            check_pos($sformatf("wall c%0d", k + 1), 0, 0, k % 5, k / 5);
            check("wall color", 32'(bus.vgaColor), 32'b001);
            check("wall vgaPlot", 32'(bus.vgaPlot), 32'd1);
            @(negedge clk);
        end
        #1;
        check_pos("wall c26", 1, 0, 5, 0);

        tile_scan(3'd2, 3'b111, hits, first);
        check("pellet count", 32'(hits), 32'd1);
        check("pellet cycle", 32'(first), 32'd13);
        tile_scan(3'd3, 3'b111, hits, first);
        check("power count", 32'(hits), 32'd9);
        check("power first", 32'(first), 32'd7);
        tile_scan(3'd4, 3'b101, hits, first);
        check("door count", 32'(hits), 32'd5);
        check("door first", 32'(first), 32'd11);
        tile_scan(3'd0, 3'b111, hits, first);
        check("empty count", 32'(hits), 32'd0);
        tile_scan(3'd6, 3'b111, hits, first);
        check("reserved count", 32'(hits), 32'd0);

        // Full pass against an index-derived position model, then the wrap
        reset_pulse();
        bus.spriteType = 3'd0;
        en = 1'b1;
        for (int k = 0; k < 11025; k++) begin
            tile = k / 25;
            p = k % 25;
            #1;
            check_pos("pass", tile % 21, tile / 21, (tile % 21) * 5 + p % 5, (tile / 21) * 5 + p / 5);
            @(negedge clk);
        end
        #1;
        check_pos("wrap", 0, 0, 0, 0);

        // Enable dropped at vga (7,3)
        reset_pulse();
        en = 1'b1;
        repeat (42) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check_pos("hold", 1, 0, 7, 3);
            check("hold vgaPlot", 32'(bus.vgaPlot), 32'd0);
            @(negedge clk);
        end
        en = 1'b1;
        #1;
        check_pos("resume", 1, 0, 7, 3);
        check("resume vgaPlot", 32'(bus.vgaPlot), 32'd1);
        @(negedge clk);
        #1;
        check_pos("resume next", 1, 0, 8, 3);

        // Reset mid-pass at tile (9,4), plus debug LEDs
        reset_pulse();
        en = 1'b1;
        repeat (2325) @(negedge clk);
        bus.spriteType = 3'd3;
        #1;
        check_pos("at 9,4", 9, 4, 45, 20);
`ifdef MAP_DISPLAY_DEBUG_EN
        check("debugLEDs", 32'(debugLEDs), 32'h64);
`else
        check("debugLEDs", 32'(debugLEDs), 32'h00);
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_pos("mid reset", 0, 0, 0, 0);
        check("mid reset vgaPlot", 32'(bus.vgaPlot), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_pos("after reset", 0, 0, 0, 0);
        check("after reset vgaPlot", 32'(bus.vgaPlot), 32'd1);
        @(negedge clk);
        #1;
        check_pos("after reset step", 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
